// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: round-robin grant of ALU/LB/ACU write-backs onto a registered common data bus
module cdb_writeback_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              alu_wr_valid,
  input  logic [TAG_W-1:0]  alu_wr_tag,
  input  logic [DATA_W-1:0] alu_wr_value,
  output logic              alu_wr_written,
  input  logic              lb_wr_valid,
  input  logic [TAG_W-1:0]  lb_wr_tag,
  input  logic [DATA_W-1:0] lb_wr_value,
  output logic              lb_wr_written,
  input  logic              acu_wr_valid,
  input  logic              acu_wr_has_dest,
  input  logic [TAG_W-1:0]  acu_wr_tag,
  input  logic [DATA_W-1:0] acu_wr_value,
  output logic              acu_wr_written,
  output logic              cdb_valid,
  output logic              cdb_has_dest,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src
);
  logic [1:0] prio, p0, p1, p2, win;
  logic [2:0] req;
  logic       grant;
  // p0..p2 is the scan order starting at the priority source; encoding 3 folds to ALU
  always_comb begin
    req   = {acu_wr_valid, lb_wr_valid, alu_wr_valid};
    p0    = prio == 2'd3 ? 2'd0 : prio;
    p1    = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    p2    = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    win   = req[p0] ? p0 : req[p1] ? p1 : p2;
    grant = !reset && !squash && |req;
  end
  assign alu_wr_written = grant && win == 2'd0;
  assign lb_wr_written  = grant && win == 2'd1;
  assign acu_wr_written = grant && win == 2'd2;
  always_ff @(posedge clock) begin
    if (reset) begin
      prio         <= 2'd0;
      cdb_valid    <= 1'b0;
      cdb_has_dest <= 1'b0;
      cdb_tag      <= '0;
      cdb_value    <= '0;
      cdb_src      <= 2'd0;
    end else begin
      cdb_valid <= grant;
      if (grant) begin
        prio         <= win == 2'd2 ? 2'd0 : win + 2'd1;
        cdb_src      <= win;
        cdb_has_dest <= win != 2'd2 || acu_wr_has_dest;
        cdb_tag      <= win == 2'd0 ? alu_wr_tag : win == 2'd1 ? lb_wr_tag : acu_wr_tag;
        cdb_value    <= win == 2'd0 ? alu_wr_value : win == 2'd1 ? lb_wr_value : acu_wr_value;
      end
    end
  end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb_cdb_writeback_arbiter: directed scoreboard bench for the CDB write-back arbiter
module tb_cdb_writeback_arbiter;
  typedef struct {
    logic        hd;
    logic [4:0]  tag;
    logic [31:0] val;
    logic [1:0]  src;
  } exp_t;
  logic clock = 0, reset = 1, squash = 0, acu_hd = 1;
  logic v [3];
  logic [4:0] tg [3];
  logic [31:0] vl [3];
  logic alu_wr_written, lb_wr_written, acu_wr_written;
  logic cdb_valid, cdb_has_dest;
  logic [4:0] cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0] cdb_src;
  exp_t q [$];
  exp_t last;
  int checks = 0, errors = 0, mprio = 0;
  bit hold = 0;
  always #5 clock = ~clock;
  cdb_writeback_arbiter #(.TAG_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .alu_wr_valid(v[0]), .alu_wr_tag(tg[0]), .alu_wr_value(vl[0]), .alu_wr_written(alu_wr_written),
    .lb_wr_valid(v[1]), .lb_wr_tag(tg[1]), .lb_wr_value(vl[1]), .lb_wr_written(lb_wr_written),
    .acu_wr_valid(v[2]), .acu_wr_has_dest(acu_hd), .acu_wr_tag(tg[2]), .acu_wr_value(vl[2]),
    .acu_wr_written(acu_wr_written),
    .cdb_valid(cdb_valid), .cdb_has_dest(cdb_has_dest), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
  );
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  // one clock cycle; exp_src is the directed winner (3 = no grant)
  task automatic tick(input int exp_src);
    exp_t e;
    bit g, rst;
    int w;
    @(negedge clock);
    g = 0;
    w = 3;
    rst = reset;
    if (!reset && !squash)
      for (int i = 0; i < 3; i++) begin
        int s = (mprio + i) % 3;
        if (!g && v[s]) begin g = 1; w = s; end
      end
    chk("winner", 64'(w), 64'(exp_src));
    chk("alu_written", 64'(alu_wr_written), 64'(w == 0));
    chk("lb_written", 64'(lb_wr_written), 64'(w == 1));
    chk("acu_written", 64'(acu_wr_written), 64'(w == 2));
    if (g) begin
      e.src = 2'(w);
      e.tag = tg[w];
      e.val = vl[w];
      e.hd = w == 2 ? acu_hd : 1'b1;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      last = '{hd: 0, tag: 0, val: 0, src: 0};
      mprio = 0;
      chk("rst_cdb_valid", 64'(cdb_valid), 0);
      chk("rst_cdb_fields", {cdb_has_dest, cdb_tag, cdb_value, cdb_src}, 0);
    end else if (g) begin
      e = q.pop_front();
      last = e;
      mprio = (w + 1) % 3;
      chk("cdb_valid", 64'(cdb_valid), 1);
      chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
      chk("cdb_value", 64'(cdb_value), 64'(e.val));
      chk("cdb_src", 64'(cdb_src), 64'(e.src));
      chk("cdb_has_dest", 64'(cdb_has_dest), 64'(e.hd));
      if (hold) begin
        tg[w] = tg[w] + 5'd1;
        vl[w] = vl[w] + 32'h111;
      end else v[w] = 0;
    end else begin
      chk("idle_cdb_valid", 64'(cdb_valid), 0);
      chk("idle_cdb_hold", {cdb_tag, cdb_value, cdb_src}, {last.tag, last.val, last.src});
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin v[i] = 0; tg[i] = 0; vl[i] = 0; end
    v[0] = 1;
    tick(3);
    tick(3);
    reset = 0;
    v[0] = 0;
    tick(3);
    // single ALU request
    v[0] = 1; tg[0] = 5'h03; vl[0] = 32'hDEAD_BEEF;
    tick(0);
    tick(3);
    // prio = 1: ACU beats ALU, then ALU
    v[0] = 1; tg[0] = 5'h04; vl[0] = 32'h1;
    v[2] = 1; tg[2] = 5'h05; vl[2] = 32'h2;
    tick(2);
    tick(0);
    // ACU store completion
    v[2] = 1; tg[2] = 5'h1F; vl[2] = 32'h0; acu_hd = 0;
    tick(2);
    acu_hd = 1;
    // three continuous requesters rotate
    hold = 1;
    for (int i = 0; i < 3; i++) begin v[i] = 1; tg[i] = 5'(8 * i + 8); vl[i] = 32'(100 * i + 7); end
    tick(0); tick(1); tick(2); tick(0); tick(1); tick(2);
    hold = 0;
    // squash suppresses everything
    squash = 1;
    tick(3);
    squash = 0;
    tick(0);
    tick(1);
    // reset while LB valid, CDB busy and prio = 2
    v[1] = 1; tg[1] = 5'h0A; vl[1] = 32'hCAFE;
    reset = 1;
    tick(3);
    reset = 0;
    v[0] = 1; tg[0] = 5'h0B; vl[0] = 32'hF00D;
    v[2] = 0;
    tick(0);
    tick(1);
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Responder side of the execution-unit write-back handshake. The ALU, load buffer and address-calc unit each raise `*_wr_valid` and hold it until they see `*_wr_written`.
- The arbiter grants at most one producer per cycle and registers the winner's result onto the common data bus (CDB). The ROB and both reservation stations consume the CDB.
- Fairness is round-robin across the three sources. A squash input suppresses grants and the bus on branch misprediction.

Parameters:
- TAG_W, 5: width of the ROB tag carried with each result.
- DATA_W, 32: width of the result value.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- squash  in  1  branch-mispredict flush (driven from ex_take_branch)
- alu_wr_valid  in  1  ALU holds a completed result
- alu_wr_tag  in  TAG_W  ROB tag of the ALU result
- alu_wr_value  in  DATA_W  ALU result value
- alu_wr_written  out  1  ALU result accepted this cycle
- lb_wr_valid  in  1  load buffer holds a completed load
- lb_wr_tag  in  TAG_W  ROB tag of the load
- lb_wr_value  in  DATA_W  loaded value
- lb_wr_written  out  1  load result accepted this cycle
- acu_wr_valid  in  1  ACU holds a completed op
- acu_wr_has_dest  in  1  1 = op writes a register; 0 = store completion
- acu_wr_tag  in  TAG_W  ROB tag of the ACU op
- acu_wr_value  in  DATA_W  ACU result value
- acu_wr_written  out  1  ACU result accepted this cycle
- cdb_valid  out  1  CDB carries a result this cycle
- cdb_has_dest  out  1  result targets a register
- cdb_tag  out  TAG_W  ROB tag on the CDB
- cdb_value  out  DATA_W  value on the CDB
- cdb_src  out  2  winning source: 0 = ALU, 1 = LB, 2 = ACU

Behaviour:
- State:
  - 2-bit priority pointer `prio` ∈ {0, 1, 2}; `prio` = the source with highest priority this cycle. Value 3 is illegal; the RTL maps it to 0.
  - CDB output register: valid, has_dest, tag, value, src.
- Reset:
  - `prio` = 0 (ALU first).
  - cdb_valid = 0, cdb_has_dest = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
  - All `*_written` = 0 while reset is high (combinational, gated by reset).
- Grant (combinational, same cycle as the request):
  - Scan sources in order prio, prio+1, prio+2, modulo 3. The first source with wr_valid = 1 wins.
  - Exactly one `*_written` is high for the winner; the others are 0.
  - No valid source: all `*_written` = 0.
  - squash = 1: all `*_written` = 0 regardless of the valids.
  - `*_written` never depends on the `*_written` outputs themselves (no combinational loop).
- Handshake rules:
  - A producer's result is consumed in exactly the cycle where its valid = 1 and written = 1.
  - A producer with valid = 1 and written = 0 must hold its tag and value stable. The arbiter does not check this.
  - A producer may raise a new valid in the cycle after its previous written.
- CDB register, updated at each posedge:
  - If a grant occurred: cdb_valid = 1, and tag/value/src come from the winner.
    - cdb_has_dest = 1 for ALU and LB winners.
    - cdb_has_dest = acu_wr_has_dest for an ACU winner.
  - Otherwise: cdb_valid = 0; tag/value/src/has_dest hold their previous values.
  - squash = 1: cdb_valid = 0 at the next edge, so a result granted in the squash cycle is never broadcast.
- Latency: request granted in cycle N → on the CDB during cycle N+1, for exactly one cycle.
- Throughput: one result per cycle sustained.
- Pointer update, at each posedge:
  - If winner w was granted: prio = (w + 1) mod 3.
  - No grant, or squash: prio unchanged.
- Fairness: with all three valid continuously, grants rotate ALU, LB, ACU, ALU, … Maximum wait for any held request is 2 cycles after its first valid cycle.
- Boundary conditions:
  - A single requester is granted every cycle it is valid, regardless of prio.
  - Reset mid-operation overrides squash and grants: all state returns to reset values at the next edge. Any pending valid is re-arbitrated after reset deasserts.
  - A store completion (acu_wr_has_dest = 0) still occupies a CDB slot and is broadcast with cdb_has_dest = 0 so the ROB can mark it complete.

Test Plan:
- Reset, then a single ALU request (alu_wr_valid = 1, tag = 5'h03, value = 32'hDEAD_BEEF) for 1 cycle → alu_wr_written = 1 in the same cycle. Next cycle: cdb_valid = 1, tag = 3, value = DEADBEEF, src = 0, has_dest = 1. The following cycle: cdb_valid = 0.
- All three valid continuously for 6 cycles, each producer presenting a new tag after each of its writtens → grant order ALU, LB, ACU, ALU, LB, ACU. Exactly one written per cycle; CDB shows the same order one cycle later.
- prio = 1 (after an ALU grant), then only ALU and ACU valid → order is ACU then ALU. prio ends at 1.
- ACU store (acu_wr_has_dest = 0, tag = 5'h1F) granted → next cycle cdb_valid = 1, cdb_has_dest = 0, cdb_tag = 31, cdb_src = 2.
- squash = 1 with all three valid → all writtens = 0, next cycle cdb_valid = 0, prio unchanged. After squash drops, the grant goes to the prio source.
- Assert reset for 1 cycle while LB is valid, with cdb_valid = 1 and prio = 2 → after reset, cdb_valid = 0 and prio = 0. If ALU and LB are then both valid, ALU is granted first.
